// File: rtl/constraint_tally.sv
// constraint_tally: tallies per-candidate split results; counts full satisfiers, first hit index, sticky fail mask.
// Optional macro CONSTRAINT_TALLY_EARLY_EXIT_EN ends the sweep on the first satisfying candidate.
module constraint_tally #(
  parameter int NUM_SPLITS = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      total,
  input  logic                  cand_valid,
  output logic                  cand_ready,
  input  logic [NUM_SPLITS-1:0] cand_x,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CNT_W-1:0]      res_sat_cnt,
  output logic [CNT_W-1:0]      res_first_idx,
  output logic                  res_found,
  output logic [NUM_SPLITS-1:0] res_fail_mask,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] total_q, total_d, idx_q, idx_d, sat_q, sat_d, first_q, first_d;
  logic found_q, found_d;
  logic [NUM_SPLITS-1:0] mask_q, mask_d;
  logic hs, all_sat, last;
  assign hs = (state_q == RUN) && cand_valid;
  assign all_sat = &cand_x;
  assign last = idx_q == total_q - CNT_W'(1);
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    idx_d = idx_q;
    sat_d = sat_q;
    first_d = first_q;
    found_d = found_q;
    mask_d = mask_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = (total != '0) ? RUN : DONE;
        total_d = total;
        idx_d = '0;
        sat_d = '0;
        first_d = '0;
        found_d = 1'b0;
        mask_d = '0;
      end
      RUN: if (hs) begin
        mask_d = mask_q | ~cand_x;
        sat_d = all_sat ? sat_q + CNT_W'(1) : sat_q;
        first_d = (all_sat && !found_q) ? idx_q : first_q;
        found_d = found_q | all_sat;
        idx_d = idx_q + CNT_W'(1);
`ifdef CONSTRAINT_TALLY_EARLY_EXIT_EN
        state_d = (last || all_sat) ? DONE : RUN;
`else
        state_d = last ? DONE : RUN;
`endif
      end
      DONE: state_d = res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      total_q <= '0;
      idx_q <= '0;
      sat_q <= '0;
      first_q <= '0;
      found_q <= 1'b0;
      mask_q <= '0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      idx_q <= idx_d;
      sat_q <= sat_d;
      first_q <= first_d;
      found_q <= found_d;
      mask_q <= mask_d;
    end
  end
  assign cand_ready = state_q == RUN;
  assign res_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign res_sat_cnt = sat_q;
  assign res_first_idx = first_q;
  assign res_found = found_q;
  assign res_fail_mask = mask_q;
endmodule

// File: tb/tb_constraint_tally.sv
// tb_constraint_tally: directed bench with a queue-based sweep model checked every cycle plus literal checks.
module tb_constraint_tally;
  localparam int NS = 4;
  localparam int CW = 8;
  logic clk = 0, rst_n = 0, start = 0, cand_valid = 0, res_ready = 0;
  logic [CW-1:0] total = 0;
  logic [NS-1:0] cand_x = 0;
  logic cand_ready, res_valid, res_found, busy;
  logic [CW-1:0] res_sat_cnt, res_first_idx;
  logic [NS-1:0] res_fail_mask;
  int errors = 0, checks = 0;

  constraint_tally #(.NUM_SPLITS(NS), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .total(total),
    .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_x(cand_x),
    .res_valid(res_valid), .res_ready(res_ready), .res_sat_cnt(res_sat_cnt),
    .res_first_idx(res_first_idx), .res_found(res_found),
    .res_fail_mask(res_fail_mask), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Model: phase 0 idle, 1 sweeping, 2 reporting; results derive from the accepted list.
  int ph = 0;
  int m_total = 0;
  logic [NS-1:0] acc[$];

  function automatic int m_sat();
    int c = 0;
    foreach (acc[i]) if (acc[i] == '1) c++;
    return c;
  endfunction
  function automatic int m_first();
    foreach (acc[i]) if (acc[i] == '1) return i;
    return 0;
  endfunction
  function automatic logic [NS-1:0] m_mask();
    logic [NS-1:0] m = '0;
    foreach (acc[i]) m |= ~acc[i];
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0;
      acc.delete();
    end else if (ph == 0) begin
      if (start) begin
        acc.delete();
        m_total = int'(total);
        ph = (total != 0) ? 1 : 2;
      end
    end else if (ph == 1) begin
      if (cand_valid) begin
        acc.push_back(cand_x);
        if (acc.size() == m_total) ph = 2;
`ifdef CONSTRAINT_TALLY_EARLY_EXIT_EN
        if (cand_x == '1) ph = 2;
`endif
      end
    end else if (res_ready) ph = 0;
  end

  always @(negedge clk) begin
    check("cand_ready", cand_ready, ph == 1);
    check("busy", busy, ph != 0);
    check("res_valid", res_valid, ph == 2);
    check("sat_cnt", res_sat_cnt, m_sat());
    check("first_idx", res_first_idx, m_first());
    check("found", res_found, m_sat() != 0);
    check("fail_mask", res_fail_mask, m_mask());
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input int t);
    start = 1;
    total = CW'(t);
    cyc();
    start = 0;
  endtask
  task automatic feed(input logic [NS-1:0] x);
    cand_valid = 1;
    cand_x = x;
    cyc();
    cand_valid = 0;
  endtask
  task automatic release_res();
    res_ready = 1;
    cyc();
    res_ready = 0;
  endtask
  task automatic lit(input string n, input int sat, input int first, input int fnd, input int mask);
    check({n, " sat"}, res_sat_cnt, sat);
    check({n, " first"}, res_first_idx, first);
    check({n, " found"}, res_found, fnd);
    check({n, " mask"}, res_fail_mask, mask);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom);
      total = CW'($urandom);
      cand_valid = 1'($urandom);
      cand_x = NS'($urandom);
      res_ready = 1'($urandom);
      cyc();
      check("rst outputs", {cand_ready, res_valid, busy, res_found, res_sat_cnt, res_first_idx, res_fail_mask}, 0);
    end
    start = 0; cand_valid = 0; res_ready = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      cand_valid = 1;
      cyc();
      check("idle cand_ready", cand_ready, 0);
    end
    cand_valid = 0;

    do_start(3);
    check("run busy", busy, 1);
    feed(4'hF); feed(4'h7); feed(4'hF);
    check("t3 res_valid", res_valid, 1);
    check("t3 cand_ready", cand_ready, 0);
    lit("t3", 2, 0, 1, 4'h8);
    release_res();

    do_start(0);
    check("t0 res_valid", res_valid, 1);
    lit("t0", 0, 0, 0, 0);
    release_res();

    do_start(2);
    feed(4'hF); feed(4'hF);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      total = 3;
      cyc();
      check("hold res_valid", res_valid, 1);
      check("hold cand_ready", cand_ready, 0);
      lit("hold", 2, 0, 1, 0);
    end
    start = 1; total = 1; res_ready = 1;
    cyc();
    start = 0; res_ready = 0;
    check("back idle busy", busy, 0);
    check("back idle res_valid", res_valid, 0);
    lit("kept", 2, 0, 1, 0);

    do_start(5);
    feed(4'h0); cyc(); feed(4'h1); cyc(); cyc(); feed(4'hF);
`ifdef CONSTRAINT_TALLY_EARLY_EXIT_EN
    check("early res_valid", res_valid, 1);
    check("early cand_ready", cand_ready, 0);
    feed(4'hF);
    check("early cand_ready2", cand_ready, 0);
    feed(4'h0);
    lit("t5", 1, 2, 1, 4'hF);
`else
    cyc(); feed(4'hF); feed(4'h0);
    check("t5 res_valid", res_valid, 1);
    lit("t5", 2, 2, 1, 4'hF);
`endif
    release_res();

    do_start(4);
    feed(4'hF); feed(4'hE);
    #2 rst_n = 0;
    #1;
    check("async rst", {cand_ready, res_valid, busy, res_found, res_sat_cnt, res_first_idx, res_fail_mask}, 0);
    @(negedge clk);
    rst_n = 1;
    cyc();
    do_start(1);
    feed(4'hF);
    check("t1 res_valid", res_valid, 1);
    lit("t1", 1, 0, 1, 0);
    release_res();
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/constraint_tally.md
# constraint_tally

Downstream collector for the split constraint checkers. Each cycle it accepts one candidate assignment's vector of single-bit constraint results (the `x` outputs of NUM_SPLITS `split_*` checkers evaluated on the same candidate). It counts candidates that satisfy every split, records the index of the first satisfying candidate, and accumulates a sticky per-split failure mask. When the sweep ends it reports the results through a valid/ready handshake.

## Interface
- NUM_SPLITS, 8, number of constraint split outputs per candidate
- CNT_W, 16, width of candidate count, index and satisfy counter
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin sweep; sampled only in IDLE
- total  in  CNT_W  candidates in sweep; sampled with start
- cand_valid  in  1  candidate result vector valid
- cand_ready  out  1  block accepts candidate
- cand_x  in  NUM_SPLITS  per-split result; bit i = split i satisfied
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_sat_cnt  out  CNT_W  candidates with cand_x all ones
- res_first_idx  out  CNT_W  index (0-based) of first satisfying candidate; 0 if none
- res_found  out  1  at least one satisfying candidate
- res_fail_mask  out  NUM_SPLITS  bit i set if split i was 0 on any accepted candidate
- busy  out  1  high in RUN and DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and total!=0 → RUN; latch total; clear idx, sat_cnt, found, first_idx and fail_mask.
  - start=1 and total==0 → DONE with all results zero.
- RUN:
  - cand_ready=1.
  - Handshake is cand_valid&cand_ready. On each handshake:
    - fail_mask |= ~cand_x.
    - If &cand_x: sat_cnt+1; if !found, set found and first_idx=idx.
    - idx+1.
  - On the handshake where idx==total-1 → DONE.
- DONE:
  - res_valid=1; all res_* held stable.
  - On res_valid&res_ready → IDLE.
- start is ignored outside IDLE. cand_valid is ignored outside RUN, and cand_ready=0 there.
- Arithmetic: idx and sat_cnt are CNT_W unsigned. sat_cnt ≤ total ≤ 2^CNT_W−1, so no overflow is possible.
- res_* outputs are the internal registers directly. They are meaningful only while res_valid=1, and keep their values in IDLE until the next start.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE and every output 0: cand_ready, res_valid, res_sat_cnt, res_first_idx, res_found, res_fail_mask, busy.
- start accepted at edge N: busy and cand_ready are high after edge N.
- Zero-latency accept: one candidate per cycle while cand_valid stays high.
- Final candidate accepted at edge M: res_valid=1 and cand_ready=0 after edge M, with results already updated.
- res_ready sampled at edge K while res_valid=1: IDLE after edge K. A start in the same cycle is not taken, because the state is not IDLE at that edge.
- total==0: res_valid high one cycle after start.
- rst_n low mid-sweep: immediate return to IDLE with all outputs cleared. The partial sweep is discarded.

## Configuration
- CONSTRAINT_TALLY_EARLY_EXIT_EN defined:
  - The first satisfying handshake moves RUN→DONE immediately, with res_sat_cnt=1 and res_found=1.
  - Remaining candidates are not consumed.
  - res_fail_mask covers only the candidates accepted so far.
- Not defined: the sweep always consumes exactly total candidates.

## Test plan
Bench uses NUM_SPLITS=4, CNT_W=8.
- Reset: hold rst_n low, drive random inputs → all outputs 0; after release, cand_ready stays 0 until start.
- start, total=3; cand_x 4'hF, 4'h7, 4'hF back-to-back → res_valid one cycle after third accept; res_sat_cnt=2, res_first_idx=0, res_found=1, res_fail_mask=4'h8.
- start, total=0 → res_valid next cycle; res_sat_cnt=0, res_found=0, res_first_idx=0, res_fail_mask=0.
- After a total=2 sweep of 4'hF, 4'hF, hold res_ready=0 for 5 cycles and pulse start → res_* stable, cand_ready=0, start ignored; res_ready=1 → IDLE next cycle, busy=0.
- total=5; cand_x 0, 4'h1, 4'hF, 4'hF, 4'h0 with cand_valid gaps:
  - Without the macro: res_sat_cnt=2, res_first_idx=2, res_fail_mask=4'hF, all 5 consumed.
  - With CONSTRAINT_TALLY_EARLY_EXIT_EN: DONE after the third accept, res_sat_cnt=1, res_first_idx=2, cand_ready=0 for the remaining two.
- total=4; assert rst_n low after 2 accepts → outputs clear asynchronously; a fresh start with total=1 and cand_x=4'hF gives res_sat_cnt=1, res_first_idx=0.
